ioctl_upload_responder: RTL and testbench

- Serves HPS upload (save) transfers of a core-side RAM region, e.g. hiscore or NVRAM, over the hps_io ioctl upload channel.
- It is the read-back counterpart of the ioctl download path that writes ROM, DIP and game-ID data into the core.
- On request it raises ioctl_upload_req, pauses the CPU, and answers each ioctl_rd strobe with one byte from RAM, using ioctl_wait to stall HPS.
- Sits in the top level between hps_io, the pause block and a RAM port.

---
 rtl/ioctl_pkg.sv | 17 +
 rtl/ioctl_upload_responder_ram_read_pipe.sv | 46 ++++
 rtl/ioctl_upload_responder.sv | 154 +++++++++++++++
 tb/tb_ioctl_upload_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ioctl_pkg.sv
// Shared types and constants for the ioctl upload path.
// Used by the upload responder and its RAM read pipe.
package ioctl_pkg;

  localparam int IOCTL_ADDR_W = 25;
  localparam logic [7:0] IOCTL_FILL_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_PAUSE,
    ST_READY,
    ST_FETCH,
    ST_HOLD
  } upl_state_e;

endpackage

// File: rtl/ioctl_upload_responder_ram_read_pipe.sv
// RAM read issue and latency tracking for the upload responder.
// One strobe in, data_valid out RAM_LAT cycles later.
module ram_read_pipe #(
  parameter int ADDR_W  = 16,
  parameter int RAM_LAT = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              start,
  input  logic              flush,
  input  logic [7:0]        ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  output logic              data_valid,
  output logic [7:0]        data_out
);

  logic [RAM_LAT-1:0] sr_q;

  assign ram_rd     = start;
  assign data_valid = sr_q[RAM_LAT-1];
  assign data_out   = ram_data;

  // read strobe delay line; its tail marks ram_data as valid
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sr_q <= '0;
    end else if (flush) begin
      sr_q <= '0;
    end else begin
      sr_q <= RAM_LAT'({sr_q, start});
    end
  end

  // RAM address is fixed at strobe acceptance
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr <= '0;
    end else if (load) begin
      ram_addr <= load_addr;
    end
  end

endmodule

// File: rtl/ioctl_upload_responder.sv
// Answers HPS upload reads with bytes from a paused core RAM region.
// Owns the session FSM, pending-save flag and ioctl_din register.
module ioctl_upload_responder
  import ioctl_pkg::*;
#(
  parameter int         ADDR_W       = 16,
  parameter int         LEN_W        = 16,
  parameter logic [7:0] UPLOAD_INDEX = 8'd4,
  parameter int         RAM_LAT      = 1
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    ioctl_upload,
  input  logic [7:0]              ioctl_index,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  input  logic                    ioctl_rd,
  output logic [7:0]              ioctl_din,
  output logic                    ioctl_wait,
  output logic                    ioctl_upload_req,
  input  logic                    save_trigger,
  input  logic [ADDR_W-1:0]       region_base,
  input  logic [LEN_W-1:0]        region_len,
  output logic                    pause_req,
  input  logic                    ram_grant,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic                    ram_rd,
  input  logic [7:0]              ram_data,
  output logic                    busy,
  output logic                    done
);

  upl_state_e state_q, state_d;

  logic       match;
  logic       in_sess;
  logic       end_sess;
  logic       accept;
  logic       start;
  logic       pend_q;
  logic       issued_q;
  logic       oor_q;
  logic       rd_valid;
  logic [7:0] rd_data;

  assign match   = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
  assign in_sess = (state_q == ST_PAUSE) || (state_q == ST_READY) ||
                   (state_q == ST_FETCH) || (state_q == ST_HOLD);
  assign end_sess = in_sess && !ioctl_upload;
  assign accept   = ((state_q == ST_READY) || (state_q == ST_HOLD)) &&
                    ioctl_rd && ram_grant;
  assign start    = (state_q == ST_FETCH) && !oor_q && !issued_q &&
                    ram_grant && ioctl_upload;
  assign busy     = (state_q != ST_IDLE);

  ram_read_pipe #(
    .ADDR_W (ADDR_W),
    .RAM_LAT(RAM_LAT)
  ) u_pipe (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .load      (accept),
    .load_addr (region_base + ioctl_addr[ADDR_W-1:0]),
    .start     (start),
    .flush     (state_q == ST_IDLE),
    .ram_data  (ram_data),
    .ram_addr  (ram_addr),
    .ram_rd    (ram_rd),
    .data_valid(rd_valid),
    .data_out  (rd_data)
  );

  // state register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // next state and handshake outputs
  always_comb begin
    state_d          = state_q;
    ioctl_upload_req = 1'b0;
    pause_req        = 1'b0;
    ioctl_wait       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (match)
          state_d = ST_PAUSE;
        else if (pend_q || (save_trigger && region_len != '0))
          state_d = ST_REQ;
      end
      ST_REQ: begin
        ioctl_upload_req = 1'b1;
        if (match) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        pause_req  = 1'b1;
        ioctl_wait = 1'b1;
        if (end_sess)       state_d = ST_IDLE;
        else if (ram_grant) state_d = ST_READY;
      end
      ST_READY, ST_HOLD: begin
        pause_req  = 1'b1;
        ioctl_wait = !ram_grant;
        if (end_sess)    state_d = ST_IDLE;
        else if (accept) state_d = ST_FETCH;
        else             state_d = ST_READY;
      end
      ST_FETCH: begin
        pause_req  = 1'b1;
        ioctl_wait = 1'b1;
        if (end_sess)               state_d = ST_IDLE;
        else if (oor_q || rd_valid) state_d = ST_HOLD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // fetch bookkeeping: range flag at acceptance, single issue per fetch
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      oor_q    <= 1'b0;
      issued_q <= 1'b0;
    end else begin
      if (accept)
        oor_q <= ioctl_addr >= IOCTL_ADDR_W'(region_len);
      if (state_q != ST_FETCH) issued_q <= 1'b0;
      else if (start)          issued_q <= 1'b1;
    end
  end

  // returned byte: fill for out-of-range, RAM data otherwise
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ioctl_din <= 8'h00;
    end else if (state_q == ST_FETCH && !end_sess) begin
      if (oor_q)         ioctl_din <= IOCTL_FILL_BYTE;
      else if (rd_valid) ioctl_din <= rd_data;
    end
  end

  // pending save collapses repeated triggers while busy
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)               pend_q <= 1'b0;
    else if (state_q == ST_IDLE) pend_q <= 1'b0;
    else if (save_trigger)       pend_q <= 1'b1;
  end

  // session completion pulse
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) done <= 1'b0;
    else          done <= end_sess;
  end

endmodule

// File: tb/tb_ioctl_upload_responder.sv
// Directed bench for ioctl_upload_responder with a 1-cycle RAM model.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_ioctl_upload_responder;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic        ioctl_rd;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        ioctl_upload_req;
  logic        save_trigger;
  logic [15:0] region_base;
  logic [15:0] region_len;
  logic        pause_req;
  logic        ram_grant;
  logic [15:0] ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_data;
  logic        busy;
  logic        done;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk_sys = ~clk_sys;

  ioctl_upload_responder dut (
    .clk_sys         (clk_sys),
    .reset_n         (reset_n),
    .ioctl_upload    (ioctl_upload),
    .ioctl_index     (ioctl_index),
    .ioctl_addr      (ioctl_addr),
    .ioctl_rd        (ioctl_rd),
    .ioctl_din       (ioctl_din),
    .ioctl_wait      (ioctl_wait),
    .ioctl_upload_req(ioctl_upload_req),
    .save_trigger    (save_trigger),
    .region_base     (region_base),
    .region_len      (region_len),
    .pause_req       (pause_req),
    .ram_grant       (ram_grant),
    .ram_addr        (ram_addr),
    .ram_rd          (ram_rd),
    .ram_data        (ram_data),
    .busy            (busy),
    .done            (done)
  );

  function automatic logic [7:0] memf(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  logic [7:0] ram_q = 8'h00;
  always @(posedge clk_sys) if (ram_rd) ram_q <= memf(ram_addr);
  assign ram_data = ram_q;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic read_byte(input logic [24:0] a, input logic [7:0] exp_din,
                           input int exp_wait, input int exp_rds,
                           input logic [15:0] exp_addr);
    int n;
    int rds;
    n = 0;
    rds = 0;
    ioctl_addr = a;
    ioctl_rd = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    while (ioctl_wait && n < 10) begin
      n++;
      if (ram_rd) begin
        rds++;
        check("ram_addr", ram_addr, exp_addr);
      end
      @(negedge clk_sys);
    end
    check("wait_cycles", n, exp_wait);
    check("ram_rd_pulses", rds, exp_rds);
    check("ioctl_din", ioctl_din, exp_din);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int dn;
    int rq;
    logic prev_req;
    logic [15:0] ea;
    reset_n      = 1'b0;
    ioctl_upload = 1'b0;
    ioctl_index  = 8'd0;
    ioctl_addr   = '0;
    ioctl_rd     = 1'b0;
    save_trigger = 1'b0;
    region_base  = 16'hFFF0;
    region_len   = 16'd16;
    ram_grant    = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("rst_req", ioctl_upload_req, 0);
    check("rst_pause", pause_req, 0);
    check("rst_wait", ioctl_wait, 0);
    check("rst_busy", busy, 0);
    check("rst_din", ioctl_din, 0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // save request, session start, pause handshake
    save_trigger = 1'b1;
    @(negedge clk_sys);
    save_trigger = 1'b0;
    check("t1_req", ioctl_upload_req, 1);
    check("t1_busy", busy, 1);
    ioctl_upload = 1'b1;
    ioctl_index  = 8'd4;
    @(negedge clk_sys);
    check("t1_req_drop", ioctl_upload_req, 0);
    check("t1_pause", pause_req, 1);
    check("t1_wait", ioctl_wait, 1);
    repeat (3) @(negedge clk_sys);
    check("t1_wait_hold", ioctl_wait, 1);
    ram_grant = 1'b1;
    @(negedge clk_sys);
    check("t1_ready_wait", ioctl_wait, 0);
    check("t1_ready_pause", pause_req, 1);

    // wrapped address read
    region_len = 16'd32;
    read_byte(25'h12, 8'h58, 2, 1, 16'h0002);

    // out-of-range read
    region_len = 16'd16;
    read_byte(25'd16, 8'hFF, 1, 0, 16'h0000);

    // whole region back-to-back
    for (int i = 0; i < 16; i++) begin
      ea = 16'hFFF0 + 16'(i);
      read_byte(25'(i), memf(ea), 2, 1, ea);
    end

    // two triggers during the session
    save_trigger = 1'b1;
    @(negedge clk_sys);
    save_trigger = 1'b0;
    @(negedge clk_sys);
    save_trigger = 1'b1;
    @(negedge clk_sys);
    save_trigger = 1'b0;

    // session end
    prev_req = ioctl_upload_req;
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    check("t4_pause_drop", pause_req, 0);
    check("t4_done", done, 1);
    dn = 1;
    rq = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_sys);
      if (done) dn++;
      if (ioctl_upload_req && !prev_req) rq++;
      check("t5_done_req_excl", done & ioctl_upload_req, 0);
      prev_req = ioctl_upload_req;
    end
    check("t4_done_count", dn, 1);
    check("t5_req_rises", rq, 1);

    // serve the pending save, then no further request
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    check("t5_req_drop", ioctl_upload_req, 0);
    @(negedge clk_sys);
    check("t5_ready_wait", ioctl_wait, 0);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    check("t5_done2", done, 1);
    rq = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_sys);
      if (ioctl_upload_req) rq++;
    end
    check("t5_no_extra_req", rq, 0);
    check("t5_idle", busy, 0);

    // reset during a fetch
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    save_trigger = 1'b1;
    @(negedge clk_sys);
    save_trigger = 1'b0;
    ioctl_addr = 25'd1;
    ioctl_rd = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    check("t6_fetch_rd", ram_rd, 1);
    reset_n = 1'b0;
    #1;
    check("t6_req", ioctl_upload_req, 0);
    check("t6_pause", pause_req, 0);
    check("t6_wait", ioctl_wait, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_din", ioctl_din, 0);
    check("t6_ram_rd", ram_rd, 0);
    check("t6_ram_addr", ram_addr, 0);
    ioctl_upload = 1'b0;
    ram_grant = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    rq = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_sys);
      if (ioctl_upload_req || busy) rq++;
    end
    check("t6_no_pending", rq, 0);

    // non-matching session index
    ioctl_index  = 8'd3;
    ioctl_upload = 1'b1;
    rq = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_sys);
      if (ioctl_wait || busy || pause_req || ioctl_upload_req) rq++;
    end
    check("t6_nomatch", rq, 0);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
